// File: rtl/tx_arb_pkg.sv
// Shared types and defaults for tx_arbiter: FSM state and grant enums plus
// the default abort command byte.
package tx_arb_pkg;

   localparam logic [2:0] ST_IDLE_ENC       = 3'd0;
   localparam logic [2:0] ST_FRAME_WAIT_ENC = 3'd1;
   localparam logic [2:0] ST_ISSUE_ENC      = 3'd2;
   localparam logic [2:0] ST_HOLD_ENC       = 3'd3;
   localparam logic [2:0] ST_WAIT_READY_ENC = 3'd4;

   // Enum values pinned to the legacy encodings so state dumps stay comparable.
   typedef enum logic [2:0] {
      ST_IDLE       = ST_IDLE_ENC,
      ST_FRAME_WAIT = ST_FRAME_WAIT_ENC,
      ST_ISSUE      = ST_ISSUE_ENC,
      ST_HOLD       = ST_HOLD_ENC,
      ST_WAIT_READY = ST_WAIT_READY_ENC
   } arb_state_t;

   typedef enum logic {
      GRANT_CMD  = 1'b0,
      GRANT_DATA = 1'b1
   } grant_t;

   localparam logic [7:0] ABORT_CMD_DEFAULT = 8'h03;

endpackage

// File: rtl/tx_arbiter.sv
// Round-robin arbiter sharing the escape-aware UART TX path between a command
// channel and a framed data channel. Optional statistics: TX_ARB_STATS_EN.
module tx_arbiter
   import tx_arb_pkg::*;
#(
   parameter int unsigned FRAME_TIMEOUT = 256,   // must be >= 2
   parameter logic [7:0]  ABORT_CMD     = ABORT_CMD_DEFAULT
) (
   input  logic        CLK_I,
   input  logic        RST_I,
   input  logic        CMD_REQ_I,
   input  logic [7:0]  CMD_I,
   output logic        CMD_ACK_O,
   input  logic        DATA_VALID_I,
   input  logic [7:0]  DATA_I,
   input  logic        DATA_LAST_I,
   output logic        DATA_READY_O,
   output logic        FRAME_ERR_O,
   input  logic        TX_READY_I,
   output logic [7:0]  DATA_SEND_O,
   output logic        WRITE_O,
   output logic [7:0]  COMMAND_O,
   output logic        WRITE_COMMAND_O
`ifdef TX_ARB_STATS_EN
   ,
   output logic [15:0] CMD_COUNT_O,
   output logic [15:0] BYTE_COUNT_O,
   output logic [7:0]  ABORT_COUNT_O
`endif
);

   localparam int unsigned   CW       = $clog2(FRAME_TIMEOUT);
   localparam logic [CW-1:0] TMO_LAST = CW'(FRAME_TIMEOUT - 1);

   arb_state_t    state;
   grant_t        last_grant;
   logic          locked;
   logic [CW-1:0] tmo_cnt;
   logic [7:0]    data_q;
   logic [7:0]    cmd_q;
   logic          write_q;
   logic          write_cmd_q;

   logic          data_ready;
   logic          grant_data;
   logic          grant_cmd;
   logic          abort;

   // Handshake outputs are combinational but forced low while reset is held.
   always_comb begin
      data_ready = 1'b0;
      grant_cmd  = 1'b0;
      abort      = 1'b0;
      if (!RST_I) begin
         case (state)
            ST_IDLE: begin
               if (TX_READY_I) begin
                  if (DATA_VALID_I && (!CMD_REQ_I || last_grant == GRANT_CMD))
                     data_ready = 1'b1;
                  else if (CMD_REQ_I)
                     grant_cmd = 1'b1;
               end
            end
            ST_FRAME_WAIT: begin
               data_ready = TX_READY_I;
               abort      = !DATA_VALID_I && (tmo_cnt == TMO_LAST);
            end
            default: ;
         endcase
      end
   end

   assign grant_data      = DATA_VALID_I && data_ready;
   assign DATA_READY_O    = data_ready;
   assign CMD_ACK_O       = grant_cmd;
   assign FRAME_ERR_O     = abort;
   assign DATA_SEND_O     = data_q;
   assign COMMAND_O       = cmd_q;
   assign WRITE_O         = write_q;
   assign WRITE_COMMAND_O = write_cmd_q;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state       <= ST_IDLE;
         last_grant  <= GRANT_DATA;
         locked      <= 1'b0;
         tmo_cnt     <= '0;
         data_q      <= '0;
         cmd_q       <= '0;
         write_q     <= 1'b0;
         write_cmd_q <= 1'b0;
      end else begin
         write_q     <= 1'b0;
         write_cmd_q <= 1'b0;
         case (state)
            ST_IDLE, ST_FRAME_WAIT: begin
               if (grant_data) begin
                  data_q     <= DATA_I;
                  write_q    <= 1'b1;
                  locked     <= !DATA_LAST_I;
                  tmo_cnt    <= '0;
                  last_grant <= GRANT_DATA;
                  state      <= ST_ISSUE;
               end else if (grant_cmd) begin
                  cmd_q       <= CMD_I;
                  write_cmd_q <= 1'b1;
                  last_grant  <= GRANT_CMD;
                  state       <= ST_ISSUE;
               end else if (abort) begin
                  // last_grant stays DATA so a held-off command wins next.
                  cmd_q       <= ABORT_CMD;
                  write_cmd_q <= 1'b1;
                  locked      <= 1'b0;
                  tmo_cnt     <= '0;
                  state       <= ST_ISSUE;
               end else if (state == ST_FRAME_WAIT && !DATA_VALID_I) begin
                  tmo_cnt <= tmo_cnt + CW'(1);
               end
            end
            ST_ISSUE:      state <= ST_HOLD;
            ST_HOLD:       state <= ST_WAIT_READY;
            ST_WAIT_READY: if (TX_READY_I) state <= locked ? ST_FRAME_WAIT : ST_IDLE;
            default:       state <= ST_IDLE;
         endcase
      end
   end

`ifdef TX_ARB_STATS_EN
   logic [15:0] cmd_count;
   logic [15:0] byte_count;
   logic [7:0]  abort_count;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         cmd_count   <= '0;
         byte_count  <= '0;
         abort_count <= '0;
      end else if (state == ST_IDLE || state == ST_FRAME_WAIT) begin
         if (grant_data)
            byte_count <= byte_count + 16'd1;
         else if (grant_cmd)
            cmd_count <= cmd_count + 16'd1;
         else if (abort)
            abort_count <= abort_count + 8'd1;
      end
   end

   assign CMD_COUNT_O   = cmd_count;
   assign BYTE_COUNT_O  = byte_count;
   assign ABORT_COUNT_O = abort_count;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomized self-checking bench for tx_arbiter: a transaction-order scoreboard
// plus per-strobe latency, spacing and exclusivity checks.
module tb_tx_arbiter;
   import tx_arb_pkg::*;

   localparam int unsigned TMO = 8;

   logic       CLK_I = 1'b0;
   logic       RST_I;
   logic       CMD_REQ_I;
   logic [7:0] CMD_I;
   logic       CMD_ACK_O;
   logic       DATA_VALID_I;
   logic [7:0] DATA_I;
   logic       DATA_LAST_I;
   logic       DATA_READY_O;
   logic       FRAME_ERR_O;
   logic       TX_READY_I;
   logic [7:0] DATA_SEND_O;
   logic       WRITE_O;
   logic [7:0] COMMAND_O;
   logic       WRITE_COMMAND_O;
`ifdef TX_ARB_STATS_EN
   logic [15:0] cmd_count;
   logic [15:0] byte_count;
   logic [7:0]  abort_count;
`endif

   tx_arbiter #(.FRAME_TIMEOUT(TMO)) dut (
      .CLK_I(CLK_I), .RST_I(RST_I),
      .CMD_REQ_I(CMD_REQ_I), .CMD_I(CMD_I), .CMD_ACK_O(CMD_ACK_O),
      .DATA_VALID_I(DATA_VALID_I), .DATA_I(DATA_I), .DATA_LAST_I(DATA_LAST_I),
      .DATA_READY_O(DATA_READY_O), .FRAME_ERR_O(FRAME_ERR_O),
      .TX_READY_I(TX_READY_I), .DATA_SEND_O(DATA_SEND_O), .WRITE_O(WRITE_O),
      .COMMAND_O(COMMAND_O), .WRITE_COMMAND_O(WRITE_COMMAND_O)
`ifdef TX_ARB_STATS_EN
      , .CMD_COUNT_O(cmd_count), .BYTE_COUNT_O(byte_count), .ABORT_COUNT_O(abort_count)
`endif
   );

   always #5 CLK_I = ~CLK_I;

   // Ready source: directed value or a random pattern (mostly high).
   logic rand_en = 1'b0;
   logic ready_force = 1'b1;
   logic rand_rdy = 1'b1;
   always @(posedge CLK_I) rand_rdy <= ($urandom_range(0, 3) != 0);
   assign TX_READY_I = rand_en ? rand_rdy : ready_force;

   int total = 0;
   int bad = 0;

   task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: expected downstream order and round-robin memory.
   typedef struct packed {
      logic       is_cmd;
      logic [7:0] b;
   } ev_t;
   ev_t  exp_q[$];
   logic mdl_last_data = 1'b1;
   int   exp_cmds = 0, exp_aborts = 0;
   int   st_cmd = 0, st_byte = 0, st_abort = 0;

   task automatic push_cmd(input logic [7:0] b);
      exp_q.push_back({1'b1, b});
      mdl_last_data = 1'b0;
      exp_cmds++;
      st_cmd++;
   endtask

   task automatic push_data(input logic [7:0] b);
      exp_q.push_back({1'b0, b});
      mdl_last_data = 1'b1;
      st_byte++;
   endtask

   task automatic push_abort();
      exp_q.push_back({1'b1, ABORT_CMD_DEFAULT});
      exp_aborts++;
      st_abort++;
   endtask

   // Monitor: every strobe matches the scoreboard head, directly follows an
   // accept, is alone, and keeps >= 4 cycles from the previous one.
   int   cyc = 0, last_strobe = -100, ack_cnt = 0, err_cnt = 0;
   logic pend = 1'b0;
   always @(negedge CLK_I) begin
      cyc++;
      if (RST_I) begin
         pend = 1'b0;
         last_strobe = -100;
      end else begin
         if (WRITE_O || WRITE_COMMAND_O || pend)
            chk_val("strobe_after_accept", WRITE_O | WRITE_COMMAND_O, pend);
         if (WRITE_O || WRITE_COMMAND_O) begin
            ev_t e;
            chk_val("single_strobe", WRITE_O & WRITE_COMMAND_O, 0);
            chk_val("strobe_spacing", (cyc - last_strobe) >= 4, 1);
            last_strobe = cyc;
            chk_val("strobe_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               chk_val("strobe_kind", WRITE_COMMAND_O, e.is_cmd);
               chk_val("strobe_byte", WRITE_COMMAND_O ? COMMAND_O : DATA_SEND_O, e.b);
            end
         end
         pend = (DATA_VALID_I && DATA_READY_O) || CMD_ACK_O || FRAME_ERR_O;
         if (CMD_ACK_O) ack_cnt++;
         if (FRAME_ERR_O) err_cnt++;
      end
   end

   task automatic tick();
      @(posedge CLK_I);
      #1;
   endtask

   task automatic drive_cmd(input logic [7:0] b);
      int n = 0;
      CMD_I = b;
      CMD_REQ_I = 1'b1;
      do begin @(negedge CLK_I); n++; end while (!CMD_ACK_O && n < 300);
      chk_val("cmd_ack_wait", CMD_ACK_O, 1);
      tick();
      CMD_REQ_I = 1'b0;
   endtask

   task automatic drive_byte(input logic [7:0] b, input logic last);
      int n = 0;
      DATA_I = b;
      DATA_LAST_I = last;
      DATA_VALID_I = 1'b1;
      do begin @(negedge CLK_I); n++; end while (!DATA_READY_O && n < 300);
      chk_val("data_ready_wait", DATA_READY_O, 1);
      tick();
      DATA_VALID_I = 1'b0;
      DATA_LAST_I = 1'b0;
   endtask

   // Command and single-byte frame raised in the same cycle.
   task automatic op_both(input logic [7:0] c, input logic [7:0] d);
      if (mdl_last_data) begin push_cmd(c); push_data(d); end
      else begin push_data(d); push_cmd(c); end
      fork
         drive_cmd(c);
         drive_byte(d, 1'b1);
      join
   endtask

   // Frame of len bytes; optional command raised after the first byte;
   // optional stall (no LAST) that must end in an abort.
   task automatic op_frame(input int unsigned len, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic with_cmd,
                           input logic [7:0] c, input logic stall);
      logic [7:0] bs [4];
      int n;
      bs[0] = b0; bs[1] = b1; bs[2] = b2; bs[3] = b3;
      for (int unsigned i = 0; i < len; i++) push_data(bs[i]);
      if (stall) push_abort();
      if (with_cmd) push_cmd(c);
      for (int unsigned i = 0; i < len; i++) begin
         if (i > 0) repeat ($urandom_range(0, 5)) tick();
         drive_byte(bs[i], (i == len - 1) && !stall);
         if (i == 0 && with_cmd) begin
            CMD_I = c;
            CMD_REQ_I = 1'b1;
         end
      end
      if (stall) begin
         n = 0;
         do begin @(negedge CLK_I); n++; end while (!FRAME_ERR_O && n < 200);
         chk_val("frame_err_wait", FRAME_ERR_O, 1);
         // Issue, hold, ready-wait, then TMO idle cycles with the pulse on the last.
         if (!rand_en) chk_val("abort_delay", n, 3 + TMO);
         tick();
      end
      if (with_cmd) drive_cmd(c);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int activity;
      RST_I = 1'b1;
      CMD_REQ_I = 1'b0; CMD_I = '0;
      DATA_VALID_I = 1'b0; DATA_I = '0; DATA_LAST_I = 1'b0;

      // Both requests raised while reset is still held: nothing may respond.
      tick();
      CMD_I = 8'hC1; CMD_REQ_I = 1'b1;
      DATA_I = 8'hD1; DATA_LAST_I = 1'b1; DATA_VALID_I = 1'b1;
      repeat (2) tick();
      @(negedge CLK_I);
      chk_val("reset_outputs", {CMD_ACK_O, DATA_READY_O, FRAME_ERR_O, WRITE_O, WRITE_COMMAND_O,
                                DATA_SEND_O, COMMAND_O}, 0);
      tick();
      RST_I = 1'b0;

      // Simultaneous requests from reset alternate CMD, DATA, CMD, ...
      op_both(8'hC1, 8'hD1);
      op_both(8'hC2, 8'hD2);
      op_both(8'hC3, 8'hD3);

      // Single command.
      push_cmd(8'h42);
      drive_cmd(8'h42);

      // Three-byte frame with a command arriving after the first byte.
      op_frame(3, 8'h10, 8'hB1, 8'h20, 8'h00, 1'b1, 8'h5C, 1'b0);

      // Stalled frame: abort, then a fresh command must be served (unlocked).
      op_frame(1, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
      push_cmd(8'h5E);
      drive_cmd(8'h5E);

      // Downstream not ready for 20 cycles: nothing may move.
      push_data(8'h77);
      drive_byte(8'h77, 1'b1);
      ready_force = 1'b0;
      push_data(8'h88);
      tick();
      fork
         drive_byte(8'h88, 1'b1);
         begin
            activity = 0;
            repeat (20) begin
               @(negedge CLK_I);
               activity += int'(DATA_READY_O | WRITE_O | WRITE_COMMAND_O | CMD_ACK_O);
            end
            chk_val("hold_quiet", activity, 0);
            tick();
            ready_force = 1'b1;
         end
      join

      // Reset during HOLD of a locked frame.
      repeat (6) tick();
      push_data(8'h55);
      drive_byte(8'h55, 1'b0);
      tick();
      RST_I = 1'b1;
      tick();
      RST_I = 1'b0;
      mdl_last_data = 1'b1;
      st_cmd = 0; st_byte = 0; st_abort = 0;
      @(negedge CLK_I);
      chk_val("post_reset_outputs", {CMD_ACK_O, DATA_READY_O, FRAME_ERR_O, WRITE_O,
                                     WRITE_COMMAND_O, DATA_SEND_O, COMMAND_O}, 0);
      tick();
      push_cmd(8'h5A);
      drive_cmd(8'h5A);

      // Randomized phase.
      rand_en = 1'b1;
      repeat (40) begin
         logic [7:0] r0, r1, r2, r3, rc;
         r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
         r3 = 8'($urandom); rc = 8'($urandom);
         case ($urandom_range(0, 3))
            0: begin push_cmd(rc); drive_cmd(rc); end
            1: op_frame($urandom_range(1, 4), r0, r1, r2, r3, 1'($urandom), rc, 1'b0);
            2: op_both(rc, r0);
            default: op_frame($urandom_range(1, 3), r0, r1, r2, r3, 1'($urandom), rc, 1'b1);
         endcase
         repeat ($urandom_range(0, 3)) tick();
      end
      rand_en = 1'b0;

      begin
         int n = 0;
         while (exp_q.size() > 0 && n < 200) begin tick(); n++; end
      end
      repeat (2) tick();
      chk_val("queue_drained", exp_q.size(), 0);
      chk_val("ack_count", ack_cnt, exp_cmds);
      chk_val("frame_err_count", err_cnt, exp_aborts);
`ifdef TX_ARB_STATS_EN
      chk_val("stat_cmd", cmd_count, st_cmd);
      chk_val("stat_byte", byte_count, st_byte);
      chk_val("stat_abort", abort_count, st_abort);
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tx_arbiter.md
Name: tx_arbiter

Overview:
- Shares the escape-aware UART TX path between two requesters:
  - a command channel (single command bytes, sent escaped);
  - a framed data channel (raw byte stream, multi-byte frames).
- Sits between the TAP-side producers and the TX escape unit.
- Drives that unit's write/write-command strobes and honours its ready signal.
- Arbitrates round-robin at frame granularity, locks the grant for a whole data frame, and aborts stalled frames with a timeout.

Parameters:
- FRAME_TIMEOUT, 256: idle cycles allowed mid-frame before abort; must be ≥ 2.
- ABORT_CMD, 8'h03: command byte emitted when a frame is aborted.

Ports:
- CLK_I  in  1  clock.
- RST_I  in  1  synchronous reset, active-high.
- CMD_REQ_I  in  1  command request; held until acknowledged.
- CMD_I  in  8  command byte; stable while CMD_REQ_I is high.
- CMD_ACK_O  out  1  one-cycle pulse when the command is issued downstream.
- DATA_VALID_I  in  1  data byte valid.
- DATA_I  in  8  data byte.
- DATA_LAST_I  in  1  marks the final byte of a frame.
- DATA_READY_O  out  1  byte accepted when DATA_VALID_I && DATA_READY_O.
- FRAME_ERR_O  out  1  one-cycle pulse on frame timeout.
- TX_READY_I  in  1  ready from the escape unit.
- DATA_SEND_O  out  8  data byte to the escape unit.
- WRITE_O  out  1  one-cycle data write strobe.
- COMMAND_O  out  8  command byte to the escape unit.
- WRITE_COMMAND_O  out  1  one-cycle command write strobe.

Behaviour:
- Reset:
  - all outputs 0;
  - state IDLE, frame lock cleared, last_grant = DATA (so the command channel wins the first tie), timeout counter 0.
  - Reset mid-operation drops any strobe and lock within that cycle's edge. No partial byte is retried.
- States: IDLE, FRAME_WAIT, ISSUE, HOLD, WAIT_READY.
- IDLE (unlocked), selection only when TX_READY_I = 1:
  - only CMD_REQ_I → grant CMD;
  - only DATA_VALID_I → grant DATA;
  - both → grant the channel != last_grant.
- Data grant:
  - DATA_READY_O = 1 combinationally in that cycle.
  - The byte is latched; lock is set unless DATA_LAST_I = 1.
- Command grant: CMD_I is latched and CMD_ACK_O pulses in the same cycle.
- Transition: IDLE → ISSUE; last_grant is updated.
- ISSUE (one cycle):
  - the latched byte drives DATA_SEND_O with WRITE_O = 1, or COMMAND_O with WRITE_COMMAND_O = 1;
  - strobes are registered outputs, never combinational.
  - ISSUE → HOLD.
- HOLD (one cycle): TX_READY_I is ignored. HOLD → WAIT_READY.
- WAIT_READY: on TX_READY_I = 1 → FRAME_WAIT if locked, else IDLE.
- FRAME_WAIT (locked), only data is served:
  - DATA_READY_O = TX_READY_I.
  - Accepted byte → ISSUE; the timeout counter clears; the lock clears if DATA_LAST_I = 1.
  - CMD_REQ_I is held off until the frame ends.
- Timeout:
  - in FRAME_WAIT, the counter increments each cycle with DATA_VALID_I = 0;
  - on reaching FRAME_TIMEOUT−1: FRAME_ERR_O pulse, lock cleared, ABORT_CMD latched as a command, → ISSUE;
  - CMD_ACK_O does not pulse for ABORT_CMD.
- After a frame ends with a pending command, that command wins next (last_grant = DATA).
- Each accepted byte and each command produces exactly one downstream strobe.
- Minimum spacing between strobes is 4 cycles.
- Latency: accept cycle N → strobe at cycle N+1.

Optional Feature:
- TX_ARB_STATS_EN defined:
  - adds outputs CMD_COUNT_O[15:0], BYTE_COUNT_O[15:0], ABORT_COUNT_O[7:0];
  - each increments on its strobe type (aborts count in ABORT_COUNT_O only), wraps modulo 2^width, clears on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package tx_arb_pkg:
  - state enum typedef;
  - grant enum (GRANT_CMD, GRANT_DATA);
  - default ABORT_CMD localparam.
- Single module, no sub-module. The timeout counter and round-robin flag are inline.

Test Plan:
- Single command 8'h42 with TX_READY_I = 1:
  - CMD_ACK_O pulses at cycle N;
  - WRITE_COMMAND_O = 1 with COMMAND_O = 8'h42 at N+1;
  - no WRITE_O.
- Three-byte frame {8'h10, 8'hB1, 8'h20} (LAST on the third) with CMD_REQ_I raised after the first byte:
  - three WRITE_O strobes in order, ≥ 4 cycles apart;
  - the command is issued only after the third byte.
- CMD_REQ_I and DATA_VALID_I asserted together from reset:
  - command first, then data;
  - repeated simultaneous requests alternate CMD, DATA, CMD.
- Frame stalled after byte 8'hAA, FRAME_TIMEOUT = 8:
  - FRAME_ERR_O pulses after 8 idle cycles;
  - WRITE_COMMAND_O issues with COMMAND_O = 8'h03;
  - returns to IDLE unlocked.
- TX_READY_I held 0 for 20 cycles after a write: no further strobe and DATA_READY_O = 0 until TX_READY_I returns to 1.
- RST_I asserted during HOLD of a frame: next cycle all outputs 0 and the lock clears; a fresh command is then serviced normally.
